// File: rtl/multi_btn_debouncer.sv
// Multi-channel button conditioner: 2-FF sync, shared-tick debounce, press/release,
// long-press detection and typematic auto-repeat for a bank of NCH buttons.
module multi_btn_debouncer #(
  parameter int unsigned NCH        = 4,
  parameter int unsigned DIV        = 50000,
  parameter int unsigned N          = 8,
  parameter int unsigned LONG_TICKS = 64,
  parameter int unsigned REP_TICKS  = 16,
  parameter bit          ACTIVE_LOW = 1'b0
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [NCH-1:0] btn_raw,
  input  logic           rep_en,
  output logic           tick,
  output logic [NCH-1:0] btn_state,
  output logic [NCH-1:0] press_pulse,
  output logic [NCH-1:0] release_pulse,
  output logic [NCH-1:0] long_pulse,
  output logic [NCH-1:0] rep_pulse
);

  localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned HW = $clog2(LONG_TICKS + 1);
  localparam int unsigned RW = $clog2(REP_TICKS + 1);

  localparam logic [CW-1:0] CNT_LAST  = CW'(DIV - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_TICKS - 1);
  localparam logic [RW-1:0] REP_LAST  = RW'(REP_TICKS - 1);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_PRESSED = 2'd1;
  localparam logic [1:0] ST_LONG    = 2'd2;

  logic [NCH-1:0] sync1, sync2, s_c;
  logic [CW-1:0]  cnt;
  logic           tick_c;

  logic [N-2:0]   hist     [NCH];
  logic [N-2:0]   hist_nx  [NCH];
  logic [1:0]     state    [NCH];
  logic [1:0]     state_nx [NCH];
  logic [HW-1:0]  hold_cnt [NCH];
  logic [HW-1:0]  hold_nx  [NCH];
  logic [RW-1:0]  rep_cnt  [NCH];
  logic [RW-1:0]  rep_nx   [NCH];
  logic [NCH-1:0] stable_nx;

  // Events latched on the tick edge, presented on the outputs one clock later
  logic [NCH-1:0] pend_press, pend_rel, pend_long, pend_rep;
  logic [NCH-1:0] pend_press_nx, pend_rel_nx, pend_long_nx, pend_rep_nx;

  // Synchronizer resets to the released level so nothing looks pressed after reset
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= {NCH{ACTIVE_LOW}};
      sync2 <= {NCH{ACTIVE_LOW}};
    end else begin
      sync1 <= btn_raw;
      sync2 <= sync1;
    end
  end

  assign s_c    = sync2 ^ {NCH{ACTIVE_LOW}};
  assign tick_c = (cnt == CNT_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else begin
      cnt  <= tick_c ? '0 : cnt + CW'(1);
      tick <= tick_c;
    end
  end

  // Next-state logic: debounce window, per-channel FSM and counters, evaluated only on tick
  always_comb begin
    logic [N-1:0] nh;
    nh            = '0;
    stable_nx     = btn_state;
    pend_press_nx = '0;
    pend_rel_nx   = '0;
    pend_long_nx  = '0;
    pend_rep_nx   = '0;
    for (int i = 0; i < int'(NCH); i++) begin
      hist_nx[i]  = hist[i];
      state_nx[i] = state[i];
      hold_nx[i]  = hold_cnt[i];
      rep_nx[i]   = rep_cnt[i];
      if (tick_c) begin
        nh         = {hist[i], s_c[i]};
        hist_nx[i] = nh[N-2:0];
        if (&nh) begin
          stable_nx[i] = 1'b1;
        end else if (~|nh) begin
          stable_nx[i] = 1'b0;
        end
        case (state[i])
          ST_IDLE: begin
            if (stable_nx[i]) begin
              state_nx[i]      = ST_PRESSED;
              hold_nx[i]       = '0;
              pend_press_nx[i] = 1'b1;
              pend_rep_nx[i]   = 1'b1;
            end
          end
          ST_PRESSED: begin
            if (!stable_nx[i]) begin
              state_nx[i]    = ST_IDLE;
              pend_rel_nx[i] = 1'b1;
            end else if (hold_cnt[i] == HOLD_LAST) begin
              state_nx[i]     = ST_LONG;
              rep_nx[i]       = '0;
              pend_long_nx[i] = 1'b1;
              pend_rep_nx[i]  = rep_en;
            end else begin
              hold_nx[i] = hold_cnt[i] + HW'(1);
            end
          end
          ST_LONG: begin
            if (!stable_nx[i]) begin
              state_nx[i]    = ST_IDLE;
              pend_rel_nx[i] = 1'b1;
            end else if (!rep_en) begin
              rep_nx[i] = '0;
            end else if (rep_cnt[i] == REP_LAST) begin
              rep_nx[i]      = '0;
              pend_rep_nx[i] = 1'b1;
            end else begin
              rep_nx[i] = rep_cnt[i] + RW'(1);
            end
          end
          default: state_nx[i] = ST_IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(NCH); i++) begin
        hist[i]     <= '0;
        state[i]    <= ST_IDLE;
        hold_cnt[i] <= '0;
        rep_cnt[i]  <= '0;
      end
      btn_state     <= '0;
      pend_press    <= '0;
      pend_rel      <= '0;
      pend_long     <= '0;
      pend_rep      <= '0;
      press_pulse   <= '0;
      release_pulse <= '0;
      long_pulse    <= '0;
      rep_pulse     <= '0;
    end else begin
      for (int i = 0; i < int'(NCH); i++) begin
        hist[i]     <= hist_nx[i];
        state[i]    <= state_nx[i];
        hold_cnt[i] <= hold_nx[i];
        rep_cnt[i]  <= rep_nx[i];
      end
      btn_state     <= stable_nx;
      pend_press    <= pend_press_nx;
      pend_rel      <= pend_rel_nx;
      pend_long     <= pend_long_nx;
      pend_rep      <= pend_rep_nx;
      press_pulse   <= pend_press;
      release_pulse <= pend_rel;
      long_pulse    <= pend_long;
      rep_pulse     <= pend_rep;
    end
  end

endmodule

// File: tb/tb_multi_btn_debouncer.sv
// Scoreboard bench: a run-length/tick-arithmetic reference model queues the expected
// outputs each clock; a monitor compares an active-high and an active-low build.
module tb_multi_btn_debouncer;

  localparam int unsigned NCH  = 2;
  localparam int unsigned DIV  = 4;
  localparam int unsigned N    = 4;
  localparam int unsigned LONG = 8;
  localparam int unsigned REP  = 3;

  typedef struct packed {
    logic           tick;
    logic [NCH-1:0] state;
    logic [NCH-1:0] press;
    logic [NCH-1:0] rel;
    logic [NCH-1:0] lng;
    logic [NCH-1:0] rep;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  logic rep_en;
  logic [NCH-1:0] press;
  logic [NCH-1:0] raw_n;

  logic           tick_a, tick_b;
  logic [NCH-1:0] state_a, pp_a, rl_a, lg_a, rp_a;
  logic [NCH-1:0] state_b, pp_b, rl_b, lg_b, rp_b;

  assign raw_n = ~press;

  multi_btn_debouncer #(.NCH(NCH), .DIV(DIV), .N(N), .LONG_TICKS(LONG), .REP_TICKS(REP),
                        .ACTIVE_LOW(1'b0)) u_dut (
    .clk(clk), .rst(rst), .btn_raw(press), .rep_en(rep_en), .tick(tick_a),
    .btn_state(state_a), .press_pulse(pp_a), .release_pulse(rl_a),
    .long_pulse(lg_a), .rep_pulse(rp_a));

  multi_btn_debouncer #(.NCH(NCH), .DIV(DIV), .N(N), .LONG_TICKS(LONG), .REP_TICKS(REP),
                        .ACTIVE_LOW(1'b1)) u_dut_al (
    .clk(clk), .rst(rst), .btn_raw(raw_n), .rep_en(rep_en), .tick(tick_b),
    .btn_state(state_b), .press_pulse(pp_b), .release_pulse(rl_b),
    .long_pulse(lg_b), .rep_pulse(rp_b));

  initial forever #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int n_press, n_rel, n_long, n_rep, n_both;
  exp_t exp_q[$];

  // Reference model state, in pressed-domain terms
  int             e_idx, tk_m;
  logic [NCH-1:0] d1, d2, stab;
  exp_t           pend;
  bit             run_val [NCH];
  int             run_len [NCH];
  int             press_tk[NCH];
  int             rep_ref [NCH];

  always @(posedge clk) begin : model
    exp_t x;
    logic [NCH-1:0] s;
    bit is_tick, ns;
    int age;
    x = '0;
    if (rst) begin
      e_idx = 0; tk_m = 0; d1 = '0; d2 = '0; stab = '0; pend = '0;
      for (int c = 0; c < NCH; c++) begin
        run_val[c] = 1'b0; run_len[c] = N - 1; press_tk[c] = 0; rep_ref[c] = 0;
      end
    end else begin
      s  = d2;
      d2 = d1;
      d1 = press;
      is_tick = ((e_idx % DIV) == DIV - 1);
      e_idx++;
      x.press = pend.press; x.rel = pend.rel; x.lng = pend.lng; x.rep = pend.rep;
      pend = '0;
      if (is_tick) begin
        tk_m++;
        for (int c = 0; c < NCH; c++) begin
          if (s[c] == run_val[c]) run_len[c]++;
          else begin run_val[c] = s[c]; run_len[c] = 1; end
          ns = (run_len[c] >= N) ? run_val[c] : stab[c];
          if (!stab[c] && ns) begin
            pend.press[c] = 1'b1; pend.rep[c] = 1'b1; press_tk[c] = tk_m;
          end else if (stab[c] && !ns) begin
            pend.rel[c] = 1'b1;
          end else if (stab[c] && ns) begin
            age = tk_m - press_tk[c];
            if (age == LONG) begin
              pend.lng[c] = 1'b1; pend.rep[c] = rep_en; rep_ref[c] = tk_m;
            end else if (age > LONG) begin
              if (!rep_en) rep_ref[c] = tk_m;
              else if (tk_m - rep_ref[c] == REP) begin
                pend.rep[c] = 1'b1; rep_ref[c] = tk_m;
              end
            end
          end
          stab[c] = ns;
        end
      end
      x.tick  = is_tick;
      x.state = stab;
    end
    exp_q.push_back(x);
  end

  task automatic cmp(input string nm, input logic [NCH-1:0] act, input logic [NCH-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @%0t: got %b expected %b", nm, $time, act, exp);
    end
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s @%0t: got %0d expected %0d", nm, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin : monitor
    exp_t x;
    if (exp_q.size() > 0) begin
      x = exp_q.pop_front();
      cmp("tick",          NCH'(tick_a), NCH'(x.tick));
      cmp("btn_state",     state_a, x.state);
      cmp("press_pulse",   pp_a,    x.press);
      cmp("release_pulse", rl_a,    x.rel);
      cmp("long_pulse",    lg_a,    x.lng);
      cmp("rep_pulse",     rp_a,    x.rep);
      cmp("al_tick",          NCH'(tick_b), NCH'(x.tick));
      cmp("al_btn_state",     state_b, x.state);
      cmp("al_press_pulse",   pp_b,    x.press);
      cmp("al_release_pulse", rl_b,    x.rel);
      cmp("al_long_pulse",    lg_b,    x.lng);
      cmp("al_rep_pulse",     rp_b,    x.rep);
    end
    n_press += int'(pp_a[0]);
    n_rel   += int'(rl_a[0]);
    n_long  += int'(lg_a[0]);
    n_rep   += int'(rp_a[0]);
    n_both  += int'(pp_a == {NCH{1'b1}});
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic clear_counts();
    n_press = 0; n_rel = 0; n_long = 0; n_rep = 0; n_both = 0;
  endtask

  task automatic wait_press(input string nm);
    int g = 0;
    while (!stab[0] && g < 200) begin cyc(1); g++; end
    if (!stab[0]) chk({nm, "_press_timeout"}, 0, 1);
  endtask

  task automatic wait_tick(input int target, input string nm);
    int g = 0;
    while (tk_m != target && g < 500) begin cyc(1); g++; end
    if (tk_m != target) chk({nm, "_tick_timeout"}, tk_m, target);
  endtask

  initial begin
    int p;
    int hold_left[NCH];
    rst = 1'b1; press = '0; rep_en = 1'b1;
    clear_counts();
    cyc(3);
    rst = 1'b0;
    cyc(6);

    // Clean press held 3 ticks, then released
    clear_counts();
    press[0] = 1'b1;
    wait_press("t1");
    cyc(12);
    press[0] = 1'b0;
    cyc(40);
    chk("t1_press_once", n_press, 1);
    chk("t1_rep_once",   n_rep,   1);
    chk("t4_release",    n_rel,   1);
    chk("t4_no_long",    n_long,  0);

    // Bouncing input never yields N equal samples, then settles high
    clear_counts();
    for (int k = 0; k < 14; k++) begin
      press[0] = ~press[0];
      cyc(3);
    end
    press[0] = 1'b1;
    cyc(40);
    chk("t2_press_once", n_press, 1);
    chk("t2_no_release", n_rel,   0);
    press[0] = 1'b0;
    cyc(40);

    // Long hold with repeat enabled: pulses at P, P+8, P+11, P+14, P+17, P+20
    clear_counts();
    press[0] = 1'b1;
    wait_press("t3");
    p = tk_m;
    wait_tick(p + 20, "t3");
    cyc(2);
    chk("t3_rep_count",  n_rep,  6);
    chk("t3_long_count", n_long, 1);
    press[0] = 1'b0;
    cyc(40);

    // Long hold with repeat disabled
    clear_counts();
    rep_en = 1'b0;
    press[0] = 1'b1;
    wait_press("t3b");
    p = tk_m;
    wait_tick(p + 20, "t3b");
    cyc(2);
    chk("t3b_rep_count",  n_rep,  1);
    chk("t3b_long_count", n_long, 1);
    press[0] = 1'b0;
    cyc(40);
    rep_en = 1'b1;

    // Fall whose 4th low sample lands on the long-press threshold tick
    clear_counts();
    press[0] = 1'b1;
    wait_press("t4b");
    p = tk_m;
    wait_tick(p + 4, "t4b");
    press[0] = 1'b0;
    cyc(40);
    chk("t4b_no_long", n_long, 0);
    chk("t4b_release", n_rel,  1);
    chk("t4b_rep",     n_rep,  1);

    // Both channels pressed in the same clock
    clear_counts();
    press = '1;
    cyc(40);
    chk("t5_both_same_clk", n_both, 1);
    press = '0;
    cyc(40);

    // Reset while in long-press with the button still held
    press[0] = 1'b1;
    wait_press("t6");
    p = tk_m;
    wait_tick(p + 10, "t6");
    clear_counts();
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    cyc(40);
    chk("t6_no_release", n_rel,   0);
    chk("t6_repress",    n_press, 1);
    press[0] = 1'b0;
    cyc(40);

    // Randomized holds, bounces, repeat-enable toggles and occasional reset
    for (int c = 0; c < NCH; c++) hold_left[c] = 1;
    for (int t = 0; t < 5000; t++) begin
      for (int c = 0; c < NCH; c++) begin
        hold_left[c]--;
        if (hold_left[c] <= 0) begin
          press[c] = ~press[c];
          hold_left[c] = ($urandom_range(0, 2) == 0) ? int'($urandom_range(40, 200))
                                                      : int'($urandom_range(1, 8));
        end
      end
      if ($urandom_range(0, 299) == 0) rep_en = ~rep_en;
      rst = ($urandom_range(0, 1999) == 0);
      cyc(1);
    end
    rst = 1'b0;
    cyc(4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
